comparador_arbitro_rr: RTL

//  Round-robin arbiter/sequencer that shares one registered unsigned comparator among N_REQ requesters.

---
 rtl/comparador_arbitro_rr.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/comparador_arbitro_rr.sv
`default_nettype none
// ============================================================================
// Module  : comparador_arbitro_rr
// Brief   : Round-robin arbiter sharing one registered unsigned comparator
//           among N_REQ requesters; returns result with done/done_id.
// Revision: 1.0
// ============================================================================
module comparador_arbitro_rr #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = (N_REQ <= 2) ? 1 : $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_bus,
  input  logic [N_REQ*WIDTH-1:0] b_bus,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   done,
  output logic [IDW-1:0]         done_id,
  output logic                   q,
  output logic                   q_lt,
  output logic                   q_gt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_RESULT  = 2'd2
  } state_t;

  localparam logic [IDW-1:0] C_LAST_RST = IDW'(N_REQ - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDW-1:0]     r_last;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [N_REQ-1:0]   r_gnt;
  logic               r_busy;
  logic               r_done;
  logic [IDW-1:0]     r_done_id;
  logic               r_q;
  logic               r_lt;
  logic               r_gt;

  logic               w_grant;
  logic               w_finish;
  logic               w_release;
  logic [IDW-1:0]     w_win;
  logic [N_REQ-1:0]   w_gnt_oh;
  logic [WIDTH-1:0]   w_a_sel;
  logic [WIDTH-1:0]   w_b_sel;
  int                 w_dist;
  int                 w_best;

  // Winner is the requester at the smallest rotated distance past r_last.
  always_comb begin
    w_win  = '0;
    w_dist = 0;
    w_best = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      w_dist = i - int'(r_last) - 1;
      if (w_dist < 0) w_dist = w_dist + N_REQ;
      if (req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_win  = IDW'(i);
      end
    end
  end

  always_comb begin
    w_gnt_oh = '0;
    w_a_sel  = '0;
    w_b_sel  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_gnt_oh[i] = 1'b1;
        w_a_sel     = a_bus[i*WIDTH +: WIDTH];
        w_b_sel     = b_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_finish    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req != '0) begin
          w_grant     = 1'b1;
          w_state_nxt = S_COMPARE;
        end
      end
      S_COMPARE: begin
        w_finish    = 1'b1;
        w_state_nxt = S_RESULT;
      end
      S_RESULT: begin
        w_release   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_release   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operands are frozen at the grant edge; later bus activity is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last    <= C_LAST_RST;
      r_a       <= '0;
      r_b       <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_q       <= 1'b0;
      r_lt      <= 1'b0;
      r_gt      <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_grant) begin
        r_last <= w_win;
        r_a    <= w_a_sel;
        r_b    <= w_b_sel;
        r_gnt  <= w_gnt_oh;
        r_busy <= 1'b1;
      end
      if (w_finish) begin
        r_done_id <= r_last;
        r_q       <= (r_a == r_b);
        r_lt      <= (r_a <  r_b);
        r_gt      <= (r_a >  r_b);
      end
      if (w_release) begin
        r_gnt  <= '0;
        r_busy <= 1'b0;
      end
    end
  end

  assign gnt     = r_gnt;
  assign busy    = r_busy;
  assign done    = r_done;
  assign done_id = r_done_id;
  assign q       = r_q;
  assign q_lt    = r_lt;
  assign q_gt    = r_gt;

endmodule
`default_nettype wire
